// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state type and the round/schedule helper functions
// shared by the stream core and its round step.
package sha256_pkg;

  // IDLE: wait for block | ROUND: compress | FINAL: fold into chain | DONE: hold digest
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  typedef logic [0:7][31:0]  hash_t;
  typedef logic [0:15][31:0] sched_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam hash_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam hash_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                             32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_step.sv
// One combinational SHA-256 compression round; word 0 is a, word 7 is h.
module sha256_round_step
  import sha256_pkg::*;
#(
  parameter int WORDSIZE = 32
) (
  input  logic [0:7][WORDSIZE-1:0] st_i,
  input  logic [WORDSIZE-1:0]      k_i,
  input  logic [WORDSIZE-1:0]      w_i,
  output logic [0:7][WORDSIZE-1:0] st_o
);

  logic [WORDSIZE-1:0] t1, t2;

  assign t1 = st_i[7] + bsig1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
  assign t2 = bsig0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);

  assign st_o[0] = t1 + t2;
  assign st_o[1] = st_i[0];
  assign st_o[2] = st_i[1];
  assign st_o[3] = st_i[2];
  assign st_o[4] = st_i[3] + t1;
  assign st_o[5] = st_i[4];
  assign st_o[6] = st_i[5];
  assign st_o[7] = st_i[6];

endmodule

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 engine with internal chaining and valid/ready block/digest ports.
// SHA256_STREAM_SHA224_EN adds a mode224 input selecting the SHA-224 IV and truncation.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int WORDSIZE         = 32
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef SHA256_STREAM_SHA224_EN
  input  logic         mode224,
`endif
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic         busy
);

  localparam int         R  = ROUNDS_PER_CYCLE;
  localparam logic [5:0] R6 = 6'(R);

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
    $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_t     state_q;
  logic [5:0] cnt_q;
  sched_t     w_q;
  hash_t      work_q, chain_q, digest_q;
  logic       last_q, open_q;
  logic       blk_ready_q, digest_valid_q, busy_q;

  logic [5:0]  cnt_d;
  sched_t      w_d;
  hash_t       chain_d, digest_d, chain_sel;
  logic [31:0] ext [16+R];
  hash_t       st [R+1];

  assign st[0] = work_q;
  for (genvar i = 0; i < R; i++) begin : g_round
    sha256_round_step #(.WORDSIZE(WORDSIZE)) u_step (
      .st_i (st[i]),
      .k_i  (K[cnt_q + 6'(i)]),
      .w_i  (w_q[i]),
      .st_o (st[i+1])
    );
  end

  // Extend the schedule window by R words so later words can use earlier new ones.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int j = 0; j < R; j++)
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    w_d = '0;
    for (int i = 0; i < 16; i++) w_d[i] = ext[i+R];
  end

  assign cnt_d = cnt_q + R6;

  always_comb begin
    chain_d = '0;
    for (int i = 0; i < 8; i++) chain_d[i] = chain_q[i] + work_q[i];
  end

`ifdef SHA256_STREAM_SHA224_EN
  logic mode_q, mode_sel;
  assign mode_sel  = (blk_first || !open_q) ? mode224 : mode_q;
  assign chain_sel = (blk_first || !open_q) ? (mode_sel ? IV224 : IV256) : chain_q;
  always_comb begin
    digest_d = chain_d;
    if (mode_q) digest_d[7] = '0;
  end
`else
  assign chain_sel = (blk_first || !open_q) ? IV256 : chain_q;
  assign digest_d  = chain_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      w_q            <= '0;
      work_q         <= '0;
      chain_q        <= IV256;
      digest_q       <= '0;
      last_q         <= 1'b0;
      open_q         <= 1'b0;
      blk_ready_q    <= 1'b0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef SHA256_STREAM_SHA224_EN
      mode_q         <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (blk_valid && blk_ready_q) begin
            w_q         <= blk_data;
            work_q      <= chain_sel;
            chain_q     <= chain_sel;
            last_q      <= blk_last;
            cnt_q       <= '0;
            blk_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ROUND;
`ifdef SHA256_STREAM_SHA224_EN
            mode_q      <= mode_sel;
`endif
          end else begin
            blk_ready_q <= 1'b1;
          end
        end
        ROUND: begin
          work_q <= st[R];
          w_q    <= w_d;
          cnt_q  <= cnt_d;
          if (cnt_d == 6'd0) state_q <= FINAL;
        end
        FINAL: begin
          chain_q <= chain_d;
          if (last_q) begin
            digest_q       <= digest_d;
            digest_valid_q <= 1'b1;
            open_q         <= 1'b0;
            state_q        <= DONE;
          end else begin
            open_q      <= 1'b1;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        DONE: begin
          if (digest_ready) begin
            digest_valid_q <= 1'b0;
            blk_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign blk_ready    = blk_ready_q;
  assign digest_valid = digest_valid_q;
  assign digest       = digest_q;
  assign busy         = busy_q;

  // A continuation block with no open message silently restarts from the IV.
  a_orphan_block: assert property (@(posedge clk) disable iff (!rst_n)
    (blk_valid && blk_ready && !blk_first) |-> open_q)
    else $warning("sha256_stream_core: continuation block with no open message, using IV");

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench for sha256_stream_core: one instance at 1 round/cycle, one at 8.
module tb_sha256_stream_core;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2    = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         rst_n, blk_valid, blk_first, blk_last, digest_ready, sel;
  logic [511:0] blk_data;
  logic         rdy1, rdy8, dv1, dv8, busy1, busy8;
  logic [255:0] dg1, dg8;
  logic         blk_ready, digest_valid, busy;
  logic [255:0] digest;
  int           checks = 0;
  int           failures = 0;
`ifdef SHA256_STREAM_SHA224_EN
  logic         mode224;
`endif

  always #5 clk = ~clk;

  assign blk_ready    = sel ? rdy8  : rdy1;
  assign digest_valid = sel ? dv8   : dv1;
  assign busy         = sel ? busy8 : busy1;
  assign digest       = sel ? dg8   : dg1;

  sha256_stream_core #(.ROUNDS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef SHA256_STREAM_SHA224_EN
    .mode224(mode224),
`endif
    .blk_valid(blk_valid & ~sel), .blk_ready(rdy1), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .digest(dg1), .digest_valid(dv1),
    .digest_ready(digest_ready), .busy(busy1)
  );

  sha256_stream_core #(.ROUNDS_PER_CYCLE(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
`ifdef SHA256_STREAM_SHA224_EN
    .mode224(mode224),
`endif
    .blk_valid(blk_valid & sel), .blk_ready(rdy8), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .digest(dg8), .digest_valid(dv8),
    .digest_ready(digest_ready), .busy(busy8)
  );

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_block(input logic [511:0] d, input logic f, input logic l);
    int n = 0;
    blk_data = d; blk_first = f; blk_last = l; blk_valid = 1'b1;
    while (!blk_ready && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (blk_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_accept blk_ready=%b after %0d cycles, expected 1", blk_ready, n);
    end
    @(posedge clk);
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  // First negedge after accept counts as 1, i.e. digest_valid sampled at edge n.
  task automatic wait_digest(input int exp_lat, input string name);
    int lat = 0;
    if (digest_valid) lat = 1;
    for (int n = 2; n <= 300 && lat == 0; n++) begin
      @(negedge clk);
      if (digest_valid) lat = n;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency got %0d, expected %0d (0 = timeout)", name, lat, exp_lat);
    end
  endtask

  task automatic take_digest(input logic [255:0] exp, input string name);
    checks++;
    if (digest !== exp) begin
      failures++;
      $display("FAIL %s digest got %h, expected %h", name, digest, exp);
    end
    digest_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    digest_ready = 1'b0;
    checks++;
    if (digest_valid !== 1'b0 || blk_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s post_handshake valid=%b ready=%b, expected valid=0 ready=1",
               name, digest_valid, blk_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    digest_ready = 1'b0; blk_data = '0;
`ifdef SHA256_STREAM_SHA224_EN
    mode224 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({rdy1, rdy8, dv1, dv8, busy1, busy8} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got rdy=%b%b valid=%b%b busy=%b%b, expected all 0",
               rdy1, rdy8, dv1, dv8, busy1, busy8);
    end
    checks++;
    if (dg1 !== '0 || dg8 !== '0) begin
      failures++;
      $display("FAIL reset_digest got %h / %h, expected 0", dg1, dg8);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy1 !== 1'b1 || rdy8 !== 1'b1) begin
      failures++;
      $display("FAIL reset_release blk_ready got %b%b, expected 11", rdy1, rdy8);
    end
  endtask

  task automatic test_abc_r1();
    sel = 1'b0;
    send_block(ABC_BLK, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b1 || blk_ready !== 1'b0) begin
      failures++;
      $display("FAIL abc_busy busy=%b ready=%b, expected busy=1 ready=0", busy, blk_ready);
    end
    wait_digest(66, "abc_r1");
    take_digest(ABC_DIG, "abc_r1");
  endtask

  task automatic test_empty_r8();
    sel = 1'b1;
    send_block(EMPTY_BLK, 1'b1, 1'b1);
    wait_digest(10, "empty_r8");
    take_digest(EMPTY_DIG, "empty_r8");
  endtask

  task automatic test_two_block();
    int n = 0;
    sel = 1'b0;
    repeat ($urandom_range(0, 4)) @(negedge clk);
    send_block(TWO_B1, 1'b1, 1'b0);
    while (!blk_ready && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (digest_valid !== 1'b0 || blk_ready !== 1'b1) begin
      failures++;
      $display("FAIL two_mid valid=%b ready=%b, expected valid=0 ready=1", digest_valid, blk_ready);
    end
    repeat ($urandom_range(0, 6)) @(negedge clk);
    send_block(TWO_B2, 1'b0, 1'b1);
    wait_digest(66, "two_block");
    take_digest(TWO_DIG, "two_block");
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    sel = 1'b1;
    send_block(ABC_BLK, 1'b1, 1'b1);
    wait_digest(10, "backpressure");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (digest_valid !== 1'b1 || digest !== ABC_DIG || blk_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold %0d bad cycles, expected 0", bad);
    end
    take_digest(ABC_DIG, "backpressure");
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (digest_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_single %0d cycles with valid/busy high, expected 0", bad);
    end
  endtask

  task automatic test_restart();
    sel = 1'b1;
    send_block(TWO_B1, 1'b1, 1'b0);
    send_block(ABC_BLK, 1'b1, 1'b1);
    wait_digest(10, "restart");
    take_digest(ABC_DIG, "restart");
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    sel = 1'b0;
    send_block(ABC_BLK, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (digest_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_mid %0d cycles with valid/busy high, expected 0", bad);
    end
    send_block(ABC_BLK, 1'b1, 1'b1);
    wait_digest(66, "reset_mid");
    take_digest(ABC_DIG, "reset_mid");
  endtask

`ifdef SHA256_STREAM_SHA224_EN
  task automatic test_sha224();
    sel = 1'b0;
    mode224 = 1'b1;
    send_block(ABC_BLK, 1'b1, 1'b1);
    mode224 = 1'b0;
    wait_digest(66, "sha224");
    take_digest(256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000, "sha224");
  endtask
`endif

  initial begin
    test_reset();
    test_abc_r1();
    test_empty_r8();
    test_two_block();
    test_back_to_back();
    test_restart();
    test_reset_mid();
`ifdef SHA256_STREAM_SHA224_EN
    test_sha224();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
